decode_issue: RTL and testbench

- Decode/issue stage sitting directly upstream of the integer ALU.
- Accepts 32-bit RV32I OP / OP-IMM instructions from fetch and reads operands from an internal 32x32 register file, with writeback bypass.
- Tracks outstanding destinations in a scoreboard and presents one registered ALU packet (op, op_imm, funct3, funct7, a, b, rd) with a valid/ready handshake.
- Writeback from downstream returns through a dedicated write port.

---
 rtl/decode_issue.sv | 169 ++++++++++++++++
 tb/tb_decode_issue.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// Decode/issue stage feeding the integer ALU: RV32I OP/OP-IMM decode,
// 32x32 register file with writeback bypass, destination scoreboard.
// Ports: clk, rst (async, active-high)
//   fetch side : in_valid, in_ready, in_instr
//   writeback  : wb_en, wb_rd, wb_data
//   ALU side   : out_valid, out_ready, out_op, out_op_imm, out_funct3,
//                out_funct7, out_a, out_b, out_rd
//   status     : illegal (one-cycle pulse after an unsupported instr)
module decode_issue #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_op,
  output logic        out_op_imm,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [4:0]  out_rd,
  output logic        illegal
);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  logic [31:0] regs [32];
  logic [31:0] pending;
  logic [31:0] pending_nxt;

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_op;
  logic        is_imm;
  logic        legal;
  logic        shift;
  logic        busy1;
  logic        busy2;
  logic        waw;
  logic        stall;
  logic        accept;
  logic [31:0] v1;
  logic [31:0] v2;
  logic [31:0] b;

  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign rd     = in_instr[11:7];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign is_op  = in_instr[6:0] == OPC_OP;
  assign is_imm = in_instr[6:0] == OPC_IMM;
  assign shift  = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      is_op: begin
        legal = (f7 == 7'h00) ||
                ((f7 == 7'h20) &&
                 ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      is_imm: begin
        unique case (f3)
          3'b001:  legal = f7 == 7'h00;
          3'b101:  legal = (f7 == 7'h00) || (f7 == 7'h20);
          default: legal = 1'b1;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Operand read with same-cycle writeback forwarding.
  assign v1 = (rs1 == 5'd0) ? 32'd0 :
              (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
  assign v2 = (rs2 == 5'd0) ? 32'd0 :
              (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];

  always_comb begin
    b = 32'd0;
    if (is_op) begin
      b = shift ? {27'd0, v2[4:0]} : v2;
    end else begin
      b = shift ? {27'd0, rs2} : {{20{in_instr[31]}}, in_instr[31:20]};
    end
  end

  // A pending source is only free when it is being written this cycle
  // and forwarding is enabled; WAW never bypasses.
  assign busy1 = (rs1 != 5'd0) && pending[rs1] &&
                 !(BYPASS && wb_en && wb_rd == rs1);
  assign busy2 = (rs2 != 5'd0) && pending[rs2] &&
                 !(BYPASS && wb_en && wb_rd == rs2);
  assign waw   = (rd != 5'd0) && pending[rd];
  assign stall = legal && (busy1 || (is_op && busy2) || waw);

  assign in_ready = (!out_valid || out_ready) && !stall;
  assign accept   = in_valid && in_ready;

  // Issue-set is applied after writeback-clear so it wins on collision.
  always_comb begin
    pending_nxt = pending;
    if (wb_en) begin
      pending_nxt[wb_rd] = 1'b0;
    end
    if (accept && legal && rd != 5'd0) begin
      pending_nxt[rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (wb_en && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 32'd0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_op     <= 1'b0;
      out_op_imm <= 1'b0;
      out_funct3 <= 3'd0;
      out_funct7 <= 7'd0;
      out_a      <= 32'd0;
      out_b      <= 32'd0;
      out_rd     <= 5'd0;
      illegal    <= 1'b0;
    end else begin
      illegal <= accept && !legal;
      if (accept && legal) begin
        out_valid  <= 1'b1;
        out_op     <= is_op;
        out_op_imm <= is_imm;
        out_funct3 <= f3;
        out_funct7 <= f7;
        out_a      <= v1;
        out_b      <= b;
        out_rd     <= rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Randomized scoreboard bench for decode_issue, run on a BYPASS=1 and a
// BYPASS=0 instance side by side, each with its own reference model.
module tb_decode_issue;

  typedef struct packed {
    logic        op;
    logic        op_imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_instr  [2];
  logic        wb_en     [2];
  logic [4:0]  wb_rd     [2];
  logic [31:0] wb_data   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        out_op    [2];
  logic        out_op_imm[2];
  logic [2:0]  out_funct3[2];
  logic [6:0]  out_funct7[2];
  logic [31:0] out_a     [2];
  logic [31:0] out_b     [2];
  logic [4:0]  out_rd    [2];
  logic        illegal   [2];

  int errors = 0;
  int checks = 0;

  pkt_t        expq [2][$];
  logic [31:0] mreg [2][32];
  logic [31:0] mpend [2];
  bit          mv [2];
  bit          mill [2];
  bit          acc_leg [2];
  bit          acc_ill [2];
  logic [4:0]  acc_rd [2];

  always #5 clk = ~clk;

  decode_issue #(.BYPASS(1'b1)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_instr(in_instr[0]),
    .wb_en(wb_en[0]), .wb_rd(wb_rd[0]), .wb_data(wb_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_op(out_op[0]), .out_op_imm(out_op_imm[0]),
    .out_funct3(out_funct3[0]), .out_funct7(out_funct7[0]),
    .out_a(out_a[0]), .out_b(out_b[0]), .out_rd(out_rd[0]),
    .illegal(illegal[0])
  );

  decode_issue #(.BYPASS(1'b0)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_instr(in_instr[1]),
    .wb_en(wb_en[1]), .wb_rd(wb_rd[1]), .wb_data(wb_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_op(out_op[1]), .out_op_imm(out_op_imm[1]),
    .out_funct3(out_funct3[1]), .out_funct7(out_funct7[1]),
    .out_a(out_a[1]), .out_b(out_b[1]), .out_rd(out_rd[1]),
    .illegal(illegal[1])
  );

  task automatic chk(input string name, input int k,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[inst%0d]: got %h expected %h", name, k, got, exp);
    end
  endtask

  function automatic bit legal_f(input logic [31:0] i);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    if (i[6:0] == 7'b0110011) begin
      if (f7 == 7'h00) return 1'b1;
      if (f7 == 7'h20) return f3 == 3'd0 || f3 == 3'd5;
      return 1'b0;
    end
    if (i[6:0] == 7'b0010011) begin
      if (f3 == 3'd1) return f7 == 7'h00;
      if (f3 == 3'd5) return f7 == 7'h00 || f7 == 7'h20;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] opval(input int k, input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_en[k] && wb_rd[k] == r) return wb_data[k];
    return mreg[k][r];
  endfunction

  function automatic bit src_busy(input int k, input logic [4:0] r);
    bit byp;
    byp = (k == 0);
    if (r == 0) return 1'b0;
    return mpend[k][r] && !(byp && wb_en[k] && wb_rd[k] == r);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0] opc;
    logic [6:0] f7;
    int sel;
    int fs;
    sel = $urandom % 10;
    if (sel == 8) return 32'h00000073;
    if (sel < 4) opc = 7'b0110011;
    else if (sel < 8) opc = 7'b0010011;
    else opc = 7'($urandom);
    fs = $urandom % 8;
    if (fs < 4) f7 = 7'h00;
    else if (fs < 7) f7 = 7'h20;
    else f7 = 7'($urandom);
    return {f7, 5'($urandom % 8), 5'($urandom % 8), 3'($urandom),
            5'($urandom % 8), opc};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) mreg[k][r] = 32'd0;
      mpend[k] = 32'd0;
      mv[k] = 1'b0;
      mill[k] = 1'b0;
      acc_leg[k] = 1'b0;
      acc_ill[k] = 1'b0;
      acc_rd[k] = 5'd0;
      expq[k].delete();
    end
  endtask

  task automatic model_update(input int k);
    if (wb_en[k] && wb_rd[k] != 0) mreg[k][wb_rd[k]] = wb_data[k];
    if (wb_en[k]) mpend[k][wb_rd[k]] = 1'b0;
    if (acc_leg[k]) begin
      mv[k] = 1'b1;
      if (acc_rd[k] != 0) mpend[k][acc_rd[k]] = 1'b1;
    end else if (out_ready[k]) begin
      mv[k] = 1'b0;
    end
    mill[k] = acc_ill[k];
    acc_leg[k] = 1'b0;
    acc_ill[k] = 1'b0;
  endtask

  task automatic drive(input int k);
    int c[$];
    wb_en[k] = ($urandom % 100) < 45;
    for (int r = 1; r < 8; r++) if (mpend[k][r]) c.push_back(r);
    if (c.size() > 0 && ($urandom % 4) != 0)
      wb_rd[k] = 5'(c[$urandom % c.size()]);
    else
      wb_rd[k] = 5'($urandom % 8);
    wb_data[k] = $urandom;
    in_valid[k] = ($urandom % 100) < 75;
    in_instr[k] = gen_instr();
    out_ready[k] = ($urandom % 100) < 70;
  endtask

  task automatic evaluate(input int k);
    logic [31:0] i;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
    bit leg;
    bit isop;
    bit stall;
    bit rdy;
    bit shf;
    pkt_t p;
    i = in_instr[k];
    s1 = i[19:15];
    s2 = i[24:20];
    d = i[11:7];
    leg = legal_f(i);
    isop = i[6:0] == 7'b0110011;
    shf = i[14:12] == 3'd1 || i[14:12] == 3'd5;
    stall = src_busy(k, s1) || (isop && src_busy(k, s2)) ||
            (d != 0 && mpend[k][d]);
    rdy = (!mv[k] || out_ready[k]) && !(leg && stall);
    chk("in_ready", k, 32'(in_ready[k]), 32'(rdy));
    if (in_valid[k] && rdy) begin
      if (leg) begin
        p.op = isop;
        p.op_imm = !isop;
        p.f3 = i[14:12];
        p.f7 = i[31:25];
        p.a = opval(k, s1);
        if (isop) p.b = shf ? opval(k, s2) % 32 : opval(k, s2);
        else p.b = shf ? 32'(s2) : 32'($signed(i[31:20]));
        p.rd = d;
        expq[k].push_back(p);
        acc_leg[k] = 1'b1;
        acc_rd[k] = d;
      end else begin
        acc_ill[k] = 1'b1;
      end
    end
  endtask

  task automatic step(input bit do_rst);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("out_valid", k, 32'(out_valid[k]), 32'(mv[k]));
      chk("illegal", k, 32'(illegal[k]), 32'(mill[k]));
    end
    if (do_rst) begin
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
        in_valid[k] = 1'b0;
        wb_en[k] = 1'b0;
      end
      #1;
      for (int k = 0; k < 2; k++)
        chk("rst_out_valid", k, 32'(out_valid[k]), 32'd0);
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b0;
      return;
    end
    for (int k = 0; k < 2; k++) drive(k);
    #1;
    for (int k = 0; k < 2; k++) evaluate(k);
  endtask

  always @(negedge clk) begin
    pkt_t e;
    pkt_t g;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (out_valid[k]) begin
          g = {out_op[k], out_op_imm[k], out_funct3[k], out_funct7[k],
               out_a[k], out_b[k], out_rd[k]};
          checks++;
          if (expq[k].size() == 0) begin
            errors++;
            $display("FAIL packet[inst%0d]: got %h with none expected",
                     k, g);
          end else begin
            e = expq[k][0];
            if (g !== e) begin
              errors++;
              $display("FAIL packet[inst%0d]: got %h expected %h",
                       k, g, e);
            end
            if (out_ready[k]) void'(expq[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      in_instr[k] = 32'd0;
      wb_en[k] = 1'b0;
      wb_rd[k] = 5'd0;
      wb_data[k] = 32'd0;
      out_ready[k] = 1'b0;
    end
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_out_valid", k, 32'(out_valid[k]), 32'd0);
      chk("reset_illegal", k, 32'(illegal[k]), 32'd0);
      chk("reset_out_a", k, out_a[k], 32'd0);
      chk("reset_out_b", k, out_b[k], 32'd0);
      chk("reset_out_rd", k, 32'(out_rd[k]), 32'd0);
      chk("reset_in_ready", k, 32'(in_ready[k]), 32'd1);
    end
    rst = 1'b0;
    for (int n = 0; n < 1500; n++) step(n == 700);
    step(1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
